// File: rtl/pc_source_reg.sv
// Next-PC source selector fused with the PC register. A redirect that arrives
// during a stall is buffered until the stall releases, and the newest redirect wins.
module pc_source_reg #(
   parameter int unsigned      WIDTH        = 32,
   parameter int unsigned      NUM_SRC      = 6,
   parameter int unsigned      SEL_W        = 3,
   parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(0),
   parameter int unsigned      ALIGN_BITS   = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [SEL_W-1:0]         selector,
   input  logic [NUM_SRC*WIDTH-1:0] data_in,
   input  logic                     pc_write,
   input  logic                     pc_write_cond,
   input  logic                     cond_true,
   input  logic                     stall,
   output logic [WIDTH-1:0]         pc_out,
   output logic [WIDTH-1:0]         pc_prev,
   output logic                     redirect_pend,
   output logic                     misaligned,
   output logic                     sel_error
);

   localparam logic [WIDTH-1:0] ALIGN_MASK =
      WIDTH'((65'(1) << ALIGN_BITS) - 65'(1));

   typedef enum logic {
      RUN  = 1'b0,
      HELD = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] pend;
   logic [WIDTH-1:0] pend_nx;
   logic [WIDTH-1:0] cand;
   logic [WIDTH-1:0] commit_val;
   logic             commit;
   logic             load;
   logic             sel_legal;
   logic             load_ok;

   assign load      = pc_write | (pc_write_cond & cond_true);
   assign sel_legal = 32'(selector) < NUM_SRC;
   assign load_ok   = load & sel_legal;

   // Candidate mux; an out-of-range selector yields zero and is never committed
   always_comb begin
      cand = '0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         if (selector == SEL_W'(k)) cand = data_in[k*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= RUN;
      else          state <= state_nx;
   end

   // Next-state, pending buffer and commit decision
   always_comb begin
      state_nx   = state;
      pend_nx    = pend;
      commit     = 1'b0;
      commit_val = pend;
      case (state)
         RUN: begin
            if (load_ok) begin
               if (stall) begin
                  pend_nx  = cand;
                  state_nx = HELD;
               end else begin
                  commit     = 1'b1;
                  commit_val = cand;
               end
            end
         end
         HELD: begin
            if (stall) begin
               if (load_ok) pend_nx = cand;
            end else begin
               commit     = 1'b1;
               commit_val = load_ok ? cand : pend;
               pend_nx    = '0;
               state_nx   = RUN;
            end
         end
         default: state_nx = RUN;
      endcase
   end

   // PC datapath and one-cycle status pulses
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend          <= '0;
         pc_out        <= RESET_VECTOR;
         pc_prev       <= RESET_VECTOR;
         redirect_pend <= 1'b0;
         misaligned    <= 1'b0;
         sel_error     <= 1'b0;
      end else begin
         pend          <= pend_nx;
         redirect_pend <= (state_nx == HELD);
         sel_error     <= load & ~sel_legal;
         misaligned    <= commit & (|(commit_val & ALIGN_MASK));
         if (commit) begin
            pc_out  <= commit_val & ~ALIGN_MASK;
            pc_prev <= pc_out;
         end
      end
   end

endmodule

// File: tb/tb_pc_source_reg.sv
// Bench for pc_source_reg: directed scenarios followed by random traffic,
// compared against a "newest legal request commits when unstalled" model.
module tb_pc_source_reg;

   localparam int unsigned W  = 32;
   localparam int unsigned NS = 6;
   localparam int unsigned SW = 3;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [SW-1:0]     selector;
   logic [NS*W-1:0]   data_in;
   logic              pc_write;
   logic              pc_write_cond;
   logic              cond_true;
   logic              stall;
   logic [W-1:0]      pc_out;
   logic [W-1:0]      pc_prev;
   logic              redirect_pend;
   logic              misaligned;
   logic              sel_error;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [W-1:0] m_pc, m_prev, m_latest;
   bit           m_has, m_mis, m_serr;

   pc_source_reg #(
      .WIDTH(W), .NUM_SRC(NS), .SEL_W(SW), .RESET_VECTOR(32'h0), .ALIGN_BITS(2)
   ) dut (
      .clk(clk), .reset_n(reset_n), .selector(selector), .data_in(data_in),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .cond_true(cond_true),
      .stall(stall), .pc_out(pc_out), .pc_prev(pc_prev),
      .redirect_pend(redirect_pend), .misaligned(misaligned), .sel_error(sel_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_prev = 32'h0; m_latest = 32'h0;
      m_has = 1'b0; m_mis = 1'b0; m_serr = 1'b0;
   endtask

   // Outcome of the upcoming clock edge, from the inputs currently driven
   task automatic model_step();
      bit           ld;
      logic [W-1:0] c;
      ld     = pc_write | (pc_write_cond & cond_true);
      c      = data_in[int'(selector)*W +: W];
      m_serr = ld && (int'(selector) >= NS);
      m_mis  = 1'b0;
      if (ld && int'(selector) < NS) begin
         m_has    = 1'b1;
         m_latest = c;
      end
      if (m_has && !stall) begin
         m_prev = m_pc;
         m_pc   = {m_latest[W-1:2], 2'b00};
         m_mis  = (m_latest[1:0] != 2'b00);
         m_has  = 1'b0;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".pc_out"},        pc_out,             m_pc);
      chk({tag, ".pc_prev"},       pc_prev,            m_prev);
      chk({tag, ".redirect_pend"}, W'(redirect_pend),  W'(m_has));
      chk({tag, ".misaligned"},    W'(misaligned),     W'(m_mis));
      chk({tag, ".sel_error"},     W'(sel_error),      W'(m_serr));
   endtask

   task automatic cycle(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic set_src(input int k, input logic [W-1:0] v);
      data_in[k*W +: W] = v;
   endtask

   initial begin
      reset_n = 1'b0; selector = '0; data_in = '0;
      pc_write = 1'b0; pc_write_cond = 1'b0; cond_true = 1'b0; stall = 1'b0;
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      check_all("reset");
      reset_n = 1'b1;

      // Unconditional load
      pc_write = 1'b1; selector = 3'd0; set_src(0, 32'h100);
      cycle("load100");
      selector = 3'd2; set_src(2, 32'h400);
      cycle("load400");
      chk("t2.pc", pc_out, 32'h400);
      chk("t2.prev", pc_prev, 32'h100);
      pc_write = 1'b0;

      // Conditional load
      pc_write_cond = 1'b1; cond_true = 1'b0; selector = 3'd1; set_src(1, 32'h80);
      cycle("cond_false");
      chk("t3.hold", pc_out, 32'h400);
      cond_true = 1'b1;
      cycle("cond_true");
      chk("t3.pc", pc_out, 32'h80);
      pc_write_cond = 1'b0; cond_true = 1'b0;

      // Redirects buffered across a stall, latest wins
      stall = 1'b1; pc_write = 1'b1; selector = 3'd3; set_src(3, 32'h200);
      cycle("stall_a");
      chk("t4.pend_a", W'(redirect_pend), 32'h1);
      set_src(3, 32'h300);
      cycle("stall_b");
      chk("t4.held", pc_out, 32'h80);
      pc_write = 1'b0;
      cycle("stall_c");
      stall = 1'b0;
      cycle("release");
      chk("t4.pc", pc_out, 32'h300);
      chk("t4.pend_clr", W'(redirect_pend), 32'h0);

      // Illegal selector
      selector = 3'd7; pc_write = 1'b1;
      cycle("sel7");
      chk("t5.serr", W'(sel_error), 32'h1);
      chk("t5.pc", pc_out, 32'h300);
      pc_write = 1'b0;
      cycle("sel7_after");
      chk("t5.serr_pulse", W'(sel_error), 32'h0);

      // Misaligned commit
      selector = 3'd4; set_src(4, 32'h1002); pc_write = 1'b1;
      cycle("misalign");
      chk("t6.pc", pc_out, 32'h1000);
      chk("t6.mis", W'(misaligned), 32'h1);
      pc_write = 1'b0;
      cycle("misalign_after");

      // Asynchronous reset mid-cycle while a redirect is buffered
      stall = 1'b1; pc_write = 1'b1; selector = 3'd5; set_src(5, 32'h2000);
      cycle("held_pre_reset");
      pc_write = 1'b0;
      #3 reset_n = 1'b0;
      #1;
      model_reset();
      check_all("async_reset");
      chk("t1.pc", pc_out, 32'h0);
      @(posedge clk); #1;
      reset_n = 1'b1; stall = 1'b0;
      cycle("after_reset");
      chk("t6.pend_lost", pc_out, 32'h0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < int'(NS); k++) set_src(k, $urandom);
         selector      = SW'($urandom_range(0, 7));
         pc_write      = ($urandom_range(0, 3) == 0);
         pc_write_cond = ($urandom_range(0, 2) == 0);
         cond_true     = $urandom_range(0, 1) == 1;
         stall         = ($urandom_range(0, 2) == 0);
         cycle("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
